// File: rtl/mem_preload_pkg.sv
// Shared types for the main-memory preload arbiter: FSM state encoding and
// bit positions inside the sticky error vector.
package mem_preload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int ERR_W    = 3;
  localparam int ERR_OOB  = 0;
  localparam int ERR_LATE = 1;
  localparam int ERR_TMO  = 2;

endpackage

// File: rtl/mem_preload_arbiter.sv
// Arbitrates the single main-memory port: the testfile loader owns it after reset
// until the image is written (or aborted), then the DUT owns it until the next reset.
module mem_preload_arbiter
  import mem_preload_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter int              DATA_W       = 64,
  parameter longint unsigned MEM_WORDS    = 64'd1 << 20,
  parameter int              LOAD_TIMEOUT = 4096,
  parameter int              CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              dut_valid,
  output logic              dut_ready,
  input  logic              dut_we,
  input  logic [ADDR_W-1:0] dut_addr,
  input  logic [DATA_W-1:0] dut_wdata,
  output logic [DATA_W-1:0] dut_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              load_done,
  output logic [CNT_W-1:0]  words_loaded,
  output logic [ERR_W-1:0]  err
);

  localparam int TMO_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT + 1) : 1;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]   words_loaded_q, words_loaded_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               load_done_q, load_done_d;
  logic               in_range;
  logic               ld_accept;

  always_comb begin
    state_d        = state_q;
    idle_cnt_d     = idle_cnt_q;
    words_loaded_d = words_loaded_q;
    err_d          = err_q;
    ld_ready       = 1'b0;
    dut_ready      = 1'b0;
    mem_valid      = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    ld_accept      = 1'b0;
    in_range       = 64'(ld_addr) < MEM_WORDS;

    case (state_q)
      ST_IDLE: begin
        state_d = load_en ? ST_LOAD : ST_RUN;
      end
      ST_LOAD: begin
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
        // Out-of-range beats are swallowed so a bad image cannot stall the loader.
        if (in_range) begin
          mem_valid = ld_valid;
          ld_ready  = mem_ready;
        end else begin
          ld_ready  = 1'b1;
        end
        ld_accept = ld_valid && ld_ready;
        if (ld_accept) begin
          idle_cnt_d = '0;
          if (!in_range) begin
            err_d[ERR_OOB] = 1'b1;
          end else if (words_loaded_q != '1) begin
            words_loaded_d = words_loaded_q + 1'b1;
          end
          if (ld_last) begin
            state_d = ST_RUN;
          end
        end else if (LOAD_TIMEOUT != 0) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_d == TMO_W'(LOAD_TIMEOUT)) begin
            err_d[ERR_TMO] = 1'b1;
            state_d        = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        mem_valid = dut_valid;
        dut_ready = mem_ready;
        mem_we    = dut_we;
        mem_addr  = dut_addr;
        mem_wdata = dut_wdata;
        if (ld_valid) begin
          err_d[ERR_LATE] = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    load_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      idle_cnt_q     <= '0;
      words_loaded_q <= '0;
      err_q          <= '0;
      load_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      words_loaded_q <= words_loaded_d;
      err_q          <= err_d;
      load_done_q    <= load_done_d;
    end
  end

  assign dut_rdata    = mem_rdata;
  assign load_done    = load_done_q;
  assign words_loaded = words_loaded_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_preload_arbiter.sv
// Directed bench for mem_preload_arbiter: a scoreboard queue of expected memory
// transactions is checked by a monitor at every memory handshake.
module tb_mem_preload_arbiter;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 64;
  localparam int          CNT_W   = 32;
  localparam logic [31:0] MEM_TOP = 32'h0010_0000;

  logic              clock;
  logic              reset_n;
  logic              load_en;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              dut_valid;
  logic              dut_ready;
  logic              dut_we;
  logic [ADDR_W-1:0] dut_addr;
  logic [DATA_W-1:0] dut_wdata;
  logic [DATA_W-1:0] dut_rdata;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              load_done;
  logic [CNT_W-1:0]  words_loaded;
  logic [2:0]        err;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } xact_t;

  xact_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  logic [DATA_W-1:0] mem_model [0:255];

  mem_preload_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MEM_WORDS(64'h0000_0000_0010_0000),
    .LOAD_TIMEOUT(8),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .load_en(load_en),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .dut_valid(dut_valid),
    .dut_ready(dut_ready),
    .dut_we(dut_we),
    .dut_addr(dut_addr),
    .dut_wdata(dut_wdata),
    .dut_rdata(dut_rdata),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .load_done(load_done),
    .words_loaded(words_loaded),
    .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Simple SRAM stand-in: writes on the handshake edge, combinational read.
  always @(posedge clock) begin
    if (mem_valid && mem_ready && mem_we) begin
      mem_model[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_model[mem_addr[7:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_xact(input logic we, input logic [31:0] addr, input logic [63:0] data);
    xact_t t;
    t.we   = we;
    t.addr = addr;
    t.data = data;
    exp_q.push_back(t);
  endtask

  // Monitor: every memory handshake must match the head of the scoreboard.
  always @(negedge clock) begin
    xact_t             t;
    logic [DATA_W-1:0] got;
    if (reset_n && mem_valid && mem_ready) begin
      got = mem_we ? mem_wdata : dut_rdata;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL mem_xact: got we=%0d addr=%h data=%h expected no transaction",
                 mem_we, mem_addr, got);
      end else begin
        t = exp_q.pop_front();
        if (t.we !== mem_we || t.addr !== mem_addr || t.data !== got) begin
          n_fail++;
          $display("FAIL mem_xact: got we=%0d addr=%h data=%h expected we=%0d addr=%h data=%h",
                   mem_we, mem_addr, got, t.we, t.addr, t.data);
        end else begin
          $display("xact we=%0d addr=%h data=%h", mem_we, mem_addr, got);
        end
      end
    end
  end

  task automatic do_reset(input logic le);
    @(posedge clock);
    #1;
    reset_n   = 1'b0;
    load_en   = le;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    dut_valid = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_dut_ready", dut_ready, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic ld_beat(input logic [31:0] addr, input logic [63:0] data,
                         input logic last, input logic mirror);
    logic done;
    done     = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    ld_last  = last;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (mirror) begin
        chk("ld_ready_mirror", ld_ready, mem_ready);
        chk("ld_mem_valid", mem_valid, 1);
      end
      if (ld_ready) begin
        done = 1'b1;
        chk("ld_mem_valid_range", mem_valid, (addr < MEM_TOP) ? 1 : 0);
      end
      @(posedge clock);
      #1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("ld_handshake", done, 1);
  endtask

  task automatic dut_req(input logic we, input logic [31:0] addr, input logic [63:0] wdata);
    logic done;
    done      = 1'b0;
    dut_valid = 1'b1;
    dut_we    = we;
    dut_addr  = addr;
    dut_wdata = wdata;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock);
      if (!load_done) chk("dut_stall", dut_ready, 0);
      if (dut_ready) done = 1'b1;
      @(posedge clock);
      #1;
    end
    dut_valid = 1'b0;
    chk("dut_handshake", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    load_en   = 1'b0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    ld_last   = 1'b0;
    dut_valid = 1'b0;
    dut_we    = 1'b0;
    dut_addr  = '0;
    dut_wdata = '0;
    mem_ready = 1'b1;

    // 1: no testfile, straight to RUN, DUT write/read round trip
    do_reset(1'b0);
    chk("t1_idle_load_done", load_done, 0);
    chk("t1_idle_dut_ready", dut_ready, 0);
    @(posedge clock);
    #1;
    chk("t1_run_load_done", load_done, 1);
    chk("t1_words", words_loaded, 0);
    chk("t1_err", err, 0);
    expect_xact(1'b1, 32'h10, 64'hAB);
    dut_req(1'b1, 32'h10, 64'hAB);
    expect_xact(1'b0, 32'h10, 64'hAB);
    dut_req(1'b0, 32'h10, 64'h0);

    // 2: four-beat image while the DUT is already requesting
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) expect_xact(1'b1, 32'(k), 64'hD000 + 64'(k));
    expect_xact(1'b1, 32'h20, 64'h55);
    fork
      begin
        for (int k = 0; k < 4; k++) ld_beat(32'(k), 64'hD000 + 64'(k), k == 3, 1'b0);
      end
      dut_req(1'b1, 32'h20, 64'h55);
    join
    chk("t2_words", words_loaded, 4);
    chk("t2_load_done", load_done, 1);
    chk("t2_err", err, 0);
    expect_xact(1'b0, 32'h2, 64'hD002);
    dut_req(1'b0, 32'h2, 64'h0);

    // 3: memory back-pressure during LOAD; late load_en change is ignored
    do_reset(1'b1);
    expect_xact(1'b1, 32'h4, 64'hE4);
    expect_xact(1'b1, 32'h5, 64'hE5);
    expect_xact(1'b1, 32'h6, 64'hE6);
    ld_beat(32'h4, 64'hE4, 1'b0, 1'b0);
    load_en   = 1'b0;
    mem_ready = 1'b0;
    fork
      ld_beat(32'h5, 64'hE5, 1'b0, 1'b1);
      begin
        repeat (2) @(posedge clock);
        #1;
        mem_ready = 1'b1;
      end
    join
    ld_beat(32'h6, 64'hE6, 1'b1, 1'b1);
    chk("t3_words", words_loaded, 3);
    chk("t3_load_done", load_done, 1);
    chk("t3_err", err, 0);

    // 4: out-of-range beats are dropped, including a final one
    do_reset(1'b1);
    ld_beat(MEM_TOP, 64'hBAD, 1'b0, 1'b0);
    chk("t4_oob_err", err, 3'b001);
    chk("t4_oob_words", words_loaded, 0);
    chk("t4_oob_load_done", load_done, 0);
    expect_xact(1'b1, MEM_TOP - 32'd1, 64'hCAFE);
    ld_beat(MEM_TOP - 32'd1, 64'hCAFE, 1'b0, 1'b0);
    chk("t4_top_words", words_loaded, 1);
    ld_beat(MEM_TOP + 32'd5, 64'hBAD2, 1'b1, 1'b0);
    chk("t4_last_oob_run", load_done, 1);
    chk("t4_last_err", err, 3'b001);
    chk("t4_last_words", words_loaded, 1);

    // 5: silent loader times out after 8 idle cycles, then a late beat
    do_reset(1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock);
      #1;
      chk("t5_waiting", load_done, 0);
    end
    @(posedge clock);
    #1;
    chk("t5_tmo_run", load_done, 1);
    chk("t5_tmo_err", err, 3'b100);
    chk("t5_tmo_words", words_loaded, 0);
    ld_valid = 1'b1;
    ld_addr  = 32'h0;
    @(negedge clock);
    chk("t5_late_ld_ready", ld_ready, 0);
    @(posedge clock);
    #1;
    ld_valid = 1'b0;
    chk("t5_late_err", err, 3'b110);

    // 6: reset in the middle of LOAD, then a full reload
    do_reset(1'b1);
    ld_beat(MEM_TOP, 64'hBAD, 1'b0, 1'b0);
    expect_xact(1'b1, 32'h0, 64'hF0);
    expect_xact(1'b1, 32'h1, 64'hF1);
    ld_beat(32'h0, 64'hF0, 1'b0, 1'b0);
    ld_beat(32'h1, 64'hF1, 1'b0, 1'b0);
    chk("t6_pre_words", words_loaded, 2);
    chk("t6_pre_err", err, 3'b001);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_words", words_loaded, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_load_done", load_done, 0);
    chk("t6_rst_ld_ready", ld_ready, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int k = 8; k < 12; k++) expect_xact(1'b1, 32'(k), 64'hA000 + 64'(k));
    for (int k = 8; k < 12; k++) ld_beat(32'(k), 64'hA000 + 64'(k), k == 11, 1'b0);
    chk("t6_words", words_loaded, 4);
    chk("t6_load_done", load_done, 1);
    chk("t6_err", err, 0);
    expect_xact(1'b0, 32'h9, 64'hA009);
    dut_req(1'b0, 32'h9, 64'h0);

    repeat (3) @(posedge clock);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
